// File: rtl/picorv_hpdc_bridge.sv
// -----------------------------------------------------------------------------
// picorv_hpdc_bridge
//
// Bridges the picorv32 native memory port to requester port 0 of the HPDcache
// wrapper. The bridge handles one access at a time:
//   1. It captures the picorv32 access.
//   2. It issues exactly one HPDcache request under a valid/ready handshake.
//   3. It waits for the response carrying the same transaction ID.
//   4. It completes the access with a single-cycle mem_ready_o pulse.
// Addresses at or above MmioBase are marked uncacheable.
// If no matching response arrives within TimeoutCycles, the bridge forces an
// error completion so the core cannot hang.
//
// Ports
//   clk_i, reset_i        clock, synchronous active-high reset
//   mem_*                 picorv32 native memory interface (valid/ready)
//   req_*                 HPDcache request channel (valid/ready, registered)
//   rsp_*                 HPDcache response channel (single-cycle pulse, no ready)
//   timeout_o             one-cycle pulse when a response timeout fires
//   err_sticky_o          set on timeout or error response, cleared by reset
//
// Timing (minimum access, req_ready_i high, response one cycle after accept)
//   edge 1 : access captured, req_valid_o rises
//   edge 2 : handshake, enter WAIT_RSP
//   edge 3 : response pulse registered
//   edge 4 : response matched, mem_ready_o high for one cycle
// -----------------------------------------------------------------------------
module picorv_hpdc_bridge #(
  parameter int          ReqOffsetWidth = 12,
  parameter int          TagWidth       = 20,
  parameter int          TidWidth       = 4,
  parameter logic [31:0] MmioBase       = 32'h0002_0000,
  parameter int          TimeoutCycles  = 1024,
  parameter logic [31:0] ErrData        = 32'hDEAD_BEEF
) (
  input  logic                      clk_i,
  input  logic                      reset_i,

  // picorv32 native memory port
  input  logic                      mem_valid_i,
  input  logic [31:0]               mem_addr_i,
  input  logic [31:0]               mem_wdata_i,
  input  logic [3:0]                mem_wstrb_i,
  output logic                      mem_ready_o,
  output logic [31:0]               mem_rdata_o,

  // HPDcache request channel
  output logic                      req_valid_o,
  input  logic                      req_ready_i,
  output logic [ReqOffsetWidth-1:0] req_addr_offset_o,
  output logic [TagWidth-1:0]       req_addr_tag_o,
  output logic [31:0]               req_wdata_o,
  output logic [3:0]                req_be_o,
  output logic                      req_store_o,
  output logic [2:0]                req_size_o,
  output logic [TidWidth-1:0]       req_tid_o,
  output logic                      req_uncacheable_o,

  // HPDcache response channel
  input  logic                      rsp_valid_i,
  input  logic [TidWidth-1:0]       rsp_tid_i,
  input  logic [31:0]               rsp_rdata_i,
  input  logic                      rsp_error_i,

  // status
  output logic                      timeout_o,
  output logic                      err_sticky_o
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REQ      = 2'd1;
  localparam logic [1:0] ST_WAIT_RSP = 2'd2;
  localparam logic [1:0] ST_RESP     = 2'd3;

  // Timeout counter is wide enough to hold TimeoutCycles-1.
  localparam int TmoWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TmoWidth-1:0] TmoLast = TmoWidth'(TimeoutCycles - 1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]                state_reg, state_next;
  logic [TidWidth-1:0]       tid_cnt_reg, tid_cnt_next;
  logic [TmoWidth-1:0]       tmo_cnt_reg, tmo_cnt_next;
  logic                      reissue_block_reg, reissue_block_next;

  logic                      req_valid_reg, req_valid_next;
  logic [ReqOffsetWidth-1:0] req_offset_reg, req_offset_next;
  logic [TagWidth-1:0]       req_tag_reg, req_tag_next;
  logic [31:0]               req_wdata_reg, req_wdata_next;
  logic [3:0]                req_be_reg, req_be_next;
  logic                      req_store_reg, req_store_next;
  logic [TidWidth-1:0]       req_tid_reg, req_tid_next;
  logic                      req_unc_reg, req_unc_next;

  logic                      mem_ready_reg, mem_ready_next;
  logic [31:0]               mem_rdata_reg, mem_rdata_next;
  logic                      timeout_reg, timeout_next;
  logic                      err_sticky_reg, err_sticky_next;

  // The response channel is registered before it is compared against the
  // outstanding tid. This keeps the tid compare and the rdata mux off the
  // wrapper's output path.
  logic                      rsp_valid_reg;
  logic [TidWidth-1:0]       rsp_tid_reg;
  logic [31:0]               rsp_rdata_reg;
  logic                      rsp_error_reg;

  // ---------------------------------------------------------------------------
  // Capture-side decode of the incoming picorv32 access
  // ---------------------------------------------------------------------------
  logic       store_sel;
  logic [3:0] be_sel;
  logic       unc_sel;

  assign store_sel = |mem_wstrb_i;
  assign unc_sel   = (mem_addr_i >= MmioBase);

  // A load reads the full word, so every byte enable is forced high.
  // A store passes its strobes through unchanged.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_be
      assign be_sel[gi] = mem_wstrb_i[gi] | ~store_sel;
    end
  endgenerate

  // A response completes the access only if its tid matches the outstanding one.
  logic rsp_match;
  assign rsp_match = rsp_valid_reg && (rsp_tid_reg == req_tid_reg);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next         = state_reg;
    tid_cnt_next       = tid_cnt_reg;
    tmo_cnt_next       = tmo_cnt_reg;
    reissue_block_next = 1'b0;

    req_valid_next     = req_valid_reg;
    req_offset_next    = req_offset_reg;
    req_tag_next       = req_tag_reg;
    req_wdata_next     = req_wdata_reg;
    req_be_next        = req_be_reg;
    req_store_next     = req_store_reg;
    req_tid_next       = req_tid_reg;
    req_unc_next       = req_unc_reg;

    mem_ready_next     = 1'b0;
    mem_rdata_next     = mem_rdata_reg;
    timeout_next       = 1'b0;
    err_sticky_next    = err_sticky_reg;

    case (state_reg)
      ST_IDLE: begin
        // The core keeps mem_valid_i high for one cycle after it has seen
        // mem_ready_o. The first IDLE cycle after a completion therefore
        // ignores mem_valid_i, so the finished access is not issued again.
        if (mem_valid_i && !reissue_block_reg) begin
          req_offset_next = mem_addr_i[ReqOffsetWidth-1:0];
          req_tag_next    = mem_addr_i[ReqOffsetWidth +: TagWidth];
          req_wdata_next  = mem_wdata_i;
          req_be_next     = be_sel;
          req_store_next  = store_sel;
          req_unc_next    = unc_sel;
          req_tid_next    = tid_cnt_reg;
          req_valid_next  = 1'b1;
          state_next      = ST_REQ;
        end
      end

      ST_REQ: begin
        // req_valid_reg is always high in this state. The request fields stay
        // frozen until the cache accepts the request.
        if (req_valid_reg && req_ready_i) begin
          req_valid_next = 1'b0;
          tid_cnt_next   = tid_cnt_reg + TidWidth'(1);
          tmo_cnt_next   = '0;
          state_next     = ST_WAIT_RSP;
        end
      end

      ST_WAIT_RSP: begin
        tmo_cnt_next = tmo_cnt_reg + TmoWidth'(1);
        // The match test comes first. If a matching response arrives in the
        // same cycle that the counter expires, the response wins and
        // timeout_o stays low.
        if (rsp_match) begin
          mem_rdata_next = rsp_error_reg ? ErrData : rsp_rdata_reg;
          if (rsp_error_reg) begin
            err_sticky_next = 1'b1;
          end
          mem_ready_next = 1'b1;
          state_next     = ST_RESP;
        end else if (tmo_cnt_reg == TmoLast) begin
          mem_rdata_next  = ErrData;
          timeout_next    = 1'b1;
          err_sticky_next = 1'b1;
          mem_ready_next  = 1'b1;
          state_next      = ST_RESP;
        end
      end

      ST_RESP: begin
        // mem_ready_o is high during this single cycle.
        reissue_block_next = 1'b1;
        state_next         = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg         <= ST_IDLE;
      tid_cnt_reg       <= '0;
      tmo_cnt_reg       <= '0;
      reissue_block_reg <= 1'b0;

      req_valid_reg     <= 1'b0;
      req_offset_reg    <= '0;
      req_tag_reg       <= '0;
      req_wdata_reg     <= '0;
      req_be_reg        <= '0;
      req_store_reg     <= 1'b0;
      req_tid_reg       <= '0;
      req_unc_reg       <= 1'b0;

      mem_ready_reg     <= 1'b0;
      mem_rdata_reg     <= '0;
      timeout_reg       <= 1'b0;
      err_sticky_reg    <= 1'b0;

      // Clearing the response capture means a response already in flight
      // when reset is asserted cannot complete a later access.
      rsp_valid_reg     <= 1'b0;
      rsp_tid_reg       <= '0;
      rsp_rdata_reg     <= '0;
      rsp_error_reg     <= 1'b0;
    end else begin
      state_reg         <= state_next;
      tid_cnt_reg       <= tid_cnt_next;
      tmo_cnt_reg       <= tmo_cnt_next;
      reissue_block_reg <= reissue_block_next;

      req_valid_reg     <= req_valid_next;
      req_offset_reg    <= req_offset_next;
      req_tag_reg       <= req_tag_next;
      req_wdata_reg     <= req_wdata_next;
      req_be_reg        <= req_be_next;
      req_store_reg     <= req_store_next;
      req_tid_reg       <= req_tid_next;
      req_unc_reg       <= req_unc_next;

      mem_ready_reg     <= mem_ready_next;
      mem_rdata_reg     <= mem_rdata_next;
      timeout_reg       <= timeout_next;
      err_sticky_reg    <= err_sticky_next;

      rsp_valid_reg     <= rsp_valid_i;
      rsp_tid_reg       <= rsp_tid_i;
      rsp_rdata_reg     <= rsp_rdata_i;
      rsp_error_reg     <= rsp_error_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_ready_o       = mem_ready_reg;
  assign mem_rdata_o       = mem_rdata_reg;

  assign req_valid_o       = req_valid_reg;
  assign req_addr_offset_o = req_offset_reg;
  assign req_addr_tag_o    = req_tag_reg;
  assign req_wdata_o       = req_wdata_reg;
  assign req_be_o          = req_be_reg;
  assign req_store_o       = req_store_reg;
  assign req_tid_o         = req_tid_reg;
  assign req_uncacheable_o = req_unc_reg;

  // Accesses are always 32-bit words (size code 2 = 4 bytes).
  assign req_size_o        = 3'd2;

  assign timeout_o         = timeout_reg;
  assign err_sticky_o      = err_sticky_reg;

endmodule

// File: tb/tb_picorv_hpdc_bridge.sv
// -----------------------------------------------------------------------------
// tb_picorv_hpdc_bridge
//
// Directed testbench for picorv_hpdc_bridge. It runs with TimeoutCycles = 16
// and covers:
//   - loads and stores
//   - MMIO marking and the boundary just below MmioBase
//   - request backpressure
//   - stale responses that must be ignored
//   - the response timeout
//   - the re-issue guard after a completion
//   - reset in the middle of a transaction
//   - an error response
// All expected values are written out by hand.
// -----------------------------------------------------------------------------
module tb_picorv_hpdc_bridge;

  localparam int TC = 16;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        mem_valid_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_wstrb_i;
  logic        mem_ready_o;
  logic [31:0] mem_rdata_o;
  logic        req_valid_o;
  logic        req_ready_i;
  logic [11:0] req_addr_offset_o;
  logic [19:0] req_addr_tag_o;
  logic [31:0] req_wdata_o;
  logic [3:0]  req_be_o;
  logic        req_store_o;
  logic [2:0]  req_size_o;
  logic [3:0]  req_tid_o;
  logic        req_uncacheable_o;
  logic        rsp_valid_i;
  logic [3:0]  rsp_tid_i;
  logic [31:0] rsp_rdata_i;
  logic        rsp_error_i;
  logic        timeout_o;
  logic        err_sticky_o;

  int n_cmp    = 0;
  int n_bad    = 0;
  int hs_count = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  picorv_hpdc_bridge #(
    .ReqOffsetWidth (12),
    .TagWidth       (20),
    .TidWidth       (4),
    .MmioBase       (32'h0002_0000),
    .TimeoutCycles  (TC),
    .ErrData        (32'hDEAD_BEEF)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .mem_valid_i       (mem_valid_i),
    .mem_addr_i        (mem_addr_i),
    .mem_wdata_i       (mem_wdata_i),
    .mem_wstrb_i       (mem_wstrb_i),
    .mem_ready_o       (mem_ready_o),
    .mem_rdata_o       (mem_rdata_o),
    .req_valid_o       (req_valid_o),
    .req_ready_i       (req_ready_i),
    .req_addr_offset_o (req_addr_offset_o),
    .req_addr_tag_o    (req_addr_tag_o),
    .req_wdata_o       (req_wdata_o),
    .req_be_o          (req_be_o),
    .req_store_o       (req_store_o),
    .req_size_o        (req_size_o),
    .req_tid_o         (req_tid_o),
    .req_uncacheable_o (req_uncacheable_o),
    .rsp_valid_i       (rsp_valid_i),
    .rsp_tid_i         (rsp_tid_i),
    .rsp_rdata_i       (rsp_rdata_i),
    .rsp_error_i       (rsp_error_i),
    .timeout_o         (timeout_o),
    .err_sticky_o      (err_sticky_o)
  );

  // Count the cycle number and the request handshakes the cache actually sees.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset_i && req_valid_o && req_ready_i) hs_count <= hs_count + 1;
  end

  // Hard stop in case the run stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Present an access to the bridge and verify the request it issues.
  // The request is held off for 'stall' cycles, and the task checks that the
  // request stays stable during that time. On return, the handshake has
  // just completed.
  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input int stall,
                       input logic exp_unc, input logic [3:0] exp_tid);
    logic [3:0] exp_be;
    exp_be      = (wstrb != 4'h0) ? wstrb : 4'hF;
    mem_valid_i = 1'b1;
    mem_addr_i  = addr;
    mem_wdata_i = wdata;
    mem_wstrb_i = wstrb;
    req_ready_i = (stall == 0);
    tick();
    check_val("req_valid",  req_valid_o, 1);
    check_val("req_offset", req_addr_offset_o, addr[11:0]);
    check_val("req_tag",    req_addr_tag_o, addr[31:12]);
    check_val("req_store",  req_store_o, (wstrb != 4'h0));
    check_val("req_be",     req_be_o, exp_be);
    check_val("req_unc",    req_uncacheable_o, exp_unc);
    check_val("req_tid",    req_tid_o, exp_tid);
    check_val("req_size",   req_size_o, 3'd2);
    if (wstrb != 4'h0) check_val("req_wdata", req_wdata_o, wdata);
    for (int i = 0; i < stall; i++) begin
      // Inputs that change after capture must not leak into the request.
      mem_addr_i  = ~addr;
      mem_wstrb_i = ~wstrb;
      tick();
      check_val("hold_valid", req_valid_o, 1);
      check_val("hold_tag",   req_addr_tag_o, addr[31:12]);
      check_val("hold_be",    req_be_o, exp_be);
    end
    mem_addr_i  = addr;
    mem_wstrb_i = wstrb;
    req_ready_i = 1'b1;
    tick();
    check_val("req_drop", req_valid_o, 0);
  endtask

  // Drive a single-cycle response pulse.
  task automatic respond(input logic [3:0] tid, input logic [31:0] data, input logic err);
    rsp_valid_i = 1'b1;
    rsp_tid_i   = tid;
    rsp_rdata_i = data;
    rsp_error_i = err;
    tick();
    rsp_valid_i = 1'b0;
    rsp_error_i = 1'b0;
  endtask

  // Wait, with a cycle limit, for mem_ready_o to go high.
  task automatic wait_ready(input int budget, output int waited);
    waited = 0;
    while (!mem_ready_o && waited < budget) begin
      tick();
      waited++;
    end
    if (!mem_ready_o) check_val("ready_budget", mem_ready_o, 1);
  endtask

  // Check that mem_ready_o lasts a single cycle, then release the core.
  task automatic complete(input logic [31:0] addr);
    $display("txn addr=%08h rdata=%08h err_sticky=%0d", addr, mem_rdata_o, err_sticky_o);
    tick();
    check_val("ready_pulse", mem_ready_o, 0);
    mem_valid_i = 1'b0;
  endtask

  int w;
  int c0;
  int hs0;
  int n;

  initial begin
    reset_i     = 1'b1;
    mem_valid_i = 1'b0;
    mem_addr_i  = '0;
    mem_wdata_i = '0;
    mem_wstrb_i = '0;
    req_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    rsp_tid_i   = '0;
    rsp_rdata_i = '0;
    rsp_error_i = 1'b0;
    tick();
    tick();
    check_val("rst_req_valid", req_valid_o, 0);
    check_val("rst_mem_ready", mem_ready_o, 0);
    check_val("rst_mem_rdata", mem_rdata_o, 0);
    check_val("rst_timeout",   timeout_o, 0);
    check_val("rst_err",       err_sticky_o, 0);
    check_val("rst_tid",       req_tid_o, 0);
    reset_i = 1'b0;
    tick();

    // Load hit with the minimum latency of 4 cycles.
    c0 = cyc;
    issue(32'h0000_0100, 32'h0, 4'h0, 0, 1'b0, 4'd0);
    respond(4'd0, 32'h1234_5678, 1'b0);
    wait_ready(8, w);
    check_val("t1_ready",   mem_ready_o, 1);
    check_val("t1_rdata",   mem_rdata_o, 32'h1234_5678);
    check_val("t1_latency", cyc - c0, 4);
    complete(32'h0000_0100);
    tick();

    // Stale response: a tid 3 response arrives while tid 1 is outstanding.
    issue(32'h0000_0200, 32'h0, 4'h0, 0, 1'b0, 4'd1);
    respond(4'd3, 32'h0000_0099, 1'b0);
    tick();
    tick();
    check_val("t4_stale_ignored", mem_ready_o, 0);
    respond(4'd1, 32'h0000_0005, 1'b0);
    wait_ready(8, w);
    check_val("t4_ready", mem_ready_o, 1);
    check_val("t4_rdata", mem_rdata_o, 32'h0000_0005);
    complete(32'h0000_0200);
    tick();

    // MMIO store with 5 cycles of backpressure; exactly one handshake expected.
    hs0 = hs_count;
    issue(32'h0002_0000, 32'hAABB_CCDD, 4'b0011, 5, 1'b1, 4'd2);
    check_val("t2_one_handshake", hs_count - hs0, 1);
    respond(4'd2, 32'h0, 1'b0);
    wait_ready(8, w);
    check_val("t2_ready", mem_ready_o, 1);
    complete(32'h0002_0000);
    tick();

    // The address just below MmioBase is cacheable.
    issue(32'h0001_FFFC, 32'h0, 4'h0, 0, 1'b0, 4'd3);
    respond(4'd3, 32'hCAFE_0003, 1'b0);
    wait_ready(8, w);
    check_val("t3_rdata", mem_rdata_o, 32'hCAFE_0003);
    complete(32'h0001_FFFC);
    tick();
    check_val("pre_tmo_err", err_sticky_o, 0);

    // Timeout: timeout_o should fire after 16 WAIT_RSP cycles.
    issue(32'h0000_0300, 32'h0, 4'h0, 0, 1'b0, 4'd4);
    n = 0;
    while (!timeout_o && n < 4 * TC) begin
      tick();
      n++;
    end
    check_val("t5_tmo_cycles", n, TC);
    check_val("t5_ready",      mem_ready_o, 1);
    check_val("t5_rdata",      mem_rdata_o, 32'hDEAD_BEEF);
    check_val("t5_err",        err_sticky_o, 1);
    complete(32'h0000_0300);
    check_val("t5_tmo_pulse",  timeout_o, 0);
    respond(4'd4, 32'h0000_0011, 1'b0);
    tick();
    tick();
    check_val("t5_late_ignored", mem_ready_o, 0);
    check_val("t5_err_hold",     err_sticky_o, 1);

    // Re-issue guard: mem_valid_i stays high for one extra cycle after the ready pulse.
    issue(32'h0000_0400, 32'h0, 4'h0, 0, 1'b0, 4'd5);
    respond(4'd5, 32'h0000_CAFE, 1'b0);
    wait_ready(8, w);
    check_val("t6_rdata", mem_rdata_o, 32'h0000_CAFE);
    $display("txn addr=%08h rdata=%08h err_sticky=%0d", 32'h0000_0400, mem_rdata_o, err_sticky_o);
    hs0 = hs_count;
    tick();
    check_val("t6_ready_pulse", mem_ready_o, 0);
    tick();
    check_val("t6_no_reissue", req_valid_o, 0);
    mem_valid_i = 1'b0;
    tick();
    check_val("t6_no_reissue2", req_valid_o, 0);
    check_val("t6_no_handshake", hs_count - hs0, 0);

    // Reset while in WAIT_RSP: all outputs return to their reset values,
    // and a late response is dropped.
    issue(32'h0003_0500, 32'h1111_2222, 4'hF, 0, 1'b1, 4'd6);
    mem_valid_i = 1'b0;
    reset_i     = 1'b1;
    tick();
    check_val("t6r_req_valid", req_valid_o, 0);
    check_val("t6r_mem_ready", mem_ready_o, 0);
    check_val("t6r_mem_rdata", mem_rdata_o, 0);
    check_val("t6r_timeout",   timeout_o, 0);
    check_val("t6r_err",       err_sticky_o, 0);
    check_val("t6r_tag",       req_addr_tag_o, 0);
    check_val("t6r_unc",       req_uncacheable_o, 0);
    check_val("t6r_be",        req_be_o, 0);
    check_val("t6r_store",     req_store_o, 0);
    check_val("t6r_wdata",     req_wdata_o, 0);
    check_val("t6r_tid",       req_tid_o, 0);
    reset_i = 1'b0;
    respond(4'd6, 32'h0000_0077, 1'b0);
    tick();
    tick();
    check_val("t6r_late_ready", mem_ready_o, 0);
    check_val("t6r_late_req",   req_valid_o, 0);

    // After reset the tid restarts at 0. An error response returns ErrData.
    issue(32'h0000_0010, 32'h0, 4'h0, 0, 1'b0, 4'd0);
    respond(4'd0, 32'h0000_ABCD, 1'b1);
    wait_ready(8, w);
    check_val("t7_rdata", mem_rdata_o, 32'hDEAD_BEEF);
    check_val("t7_err",   err_sticky_o, 1);
    check_val("t7_no_tmo", timeout_o, 0);
    complete(32'h0000_0010);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
